// File: rtl/VX_tb_common_pkg.sv
// ----------------------------------------------------------------------------
// VX_tb_common_pkg
// Shared types for the RISC-V instruction sequencer / program-write path.
//   instr_type_e       : instruction format selector (R/I/S/B/U/J)
//   risc_v_seq_instr_t : decoded instruction fields offered by a sequencer
//   RISC_V_SEQ_INSTR_W : packed width of risc_v_seq_instr_t
//   RV_NOP_WORD        : addi x0,x0,0, emitted for unsupported formats
//   arb_state_e        : arbiter output-register state
// ----------------------------------------------------------------------------
package VX_tb_common_pkg;

    // Encodings 6 and 7 are unsupported; they encode as RV_NOP_WORD.
    typedef enum logic [2:0] {
        INSTR_R = 3'd0,
        INSTR_I = 3'd1,
        INSTR_S = 3'd2,
        INSTR_B = 3'd3,
        INSTR_U = 3'd4,
        INSTR_J = 3'd5
    } instr_type_e;

    // I and U formats take their immediate from imm0. The split formats
    // (S/B/J) take the upper word fields from imm1 and the lower ones from imm0.
    typedef struct packed {
        instr_type_e instr_type;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm0;
        logic [31:0] imm1;
    } risc_v_seq_instr_t;

    localparam int RISC_V_SEQ_INSTR_W = $bits(risc_v_seq_instr_t);

    localparam logic [31:0] RV_NOP_WORD = 32'h0000_0013;

    typedef enum logic {
        ARB_IDLE = 1'b0,   // output register empty
        ARB_EMIT = 1'b1    // output register holds a word
    } arb_state_e;

endpackage

// File: rtl/risc_v_inst_encoder.sv
// ----------------------------------------------------------------------------
// risc_v_inst_encoder
// Combinational RV32 encoder: packs decoded fields into a 32-bit word.
//   instr   : risc_v_seq_instr_t, decoded fields
//   word    : encoded RV32 instruction
//   illegal : instr_type is not one of R/I/S/B/U/J (word is RV_NOP_WORD)
// ----------------------------------------------------------------------------
module risc_v_inst_encoder
    import VX_tb_common_pkg::*;
(
    input  risc_v_seq_instr_t instr,
    output logic [31:0]       word,
    output logic              illegal
);

    logic [31:0] imm0;
    logic [31:0] imm1;

    assign imm0 = instr.imm0;
    assign imm1 = instr.imm1;

    // imm1 only supplies the upper fields of S/B/J; these bits never reach a word.
    logic unused_imm1_bits;
    assign unused_imm1_bits = ^{imm1[31:21], imm1[19:13], imm1[0]};

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would infer a latch.
        word    = RV_NOP_WORD;
        illegal = 1'b0;
        case (instr.instr_type)
            INSTR_R: word = {instr.funct7, instr.rs2, instr.rs1, instr.funct3,
                             instr.rd, instr.opcode};
            INSTR_I: word = {imm0[11:0], instr.rs1, instr.funct3, instr.rd,
                             instr.opcode};
            INSTR_S: word = {imm1[11:5], instr.rs2, instr.rs1, instr.funct3,
                             imm0[4:0], instr.opcode};
            INSTR_B: word = {imm1[12], imm1[10:5], instr.rs2, instr.rs1,
                             instr.funct3, imm0[4:1], imm0[11], instr.opcode};
            INSTR_U: word = {imm0[31:12], instr.rd, instr.opcode};
            INSTR_J: word = {imm1[20], imm1[10:1], imm0[11], imm0[19:12],
                             instr.rd, instr.opcode};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/risc_v_inst_arbiter.sv
// ----------------------------------------------------------------------------
// risc_v_inst_arbiter
// Round-robin scheduler sharing one encode/program-write path between
// NUM_REQ instruction sequencers. The winner's fields are encoded and emitted
// with a sequential program address; program fill is tracked up to MAX_INSTRS.
//
// Optional feature (macro VX_TB_INST_ARB_LOCK_EN): adds req_lock. An accept
// with the grantee's lock bit set keeps the grant on that requester until an
// accept with the lock bit low.
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   clear                 : synchronous restart of program fill
//   req_valid/req_instr   : per-requester offer (risc_v_seq_instr_t)
//   req_lock              : per-requester lock (feature build only)
//   req_ready             : per-requester accept, one-hot or zero
//   out_valid/out_ready   : encoded-word handshake toward the loader
//   out_addr/out_data     : program address and encoded RV32 word
//   out_src               : requester that produced out_data
//   full                  : MAX_INSTRS words issued
//   done                  : full and output register empty
//   err_illegal           : sticky, an unsupported instr_type was accepted
// ----------------------------------------------------------------------------
module risc_v_inst_arbiter
    import VX_tb_common_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          MAX_INSTRS = 1024,
    localparam int         SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  clear,
    input  logic              [NUM_REQ-1:0]       req_valid,
    input  risc_v_seq_instr_t [NUM_REQ-1:0]       req_instr,
`ifdef VX_TB_INST_ARB_LOCK_EN
    input  logic              [NUM_REQ-1:0]       req_lock,
`endif
    output logic              [NUM_REQ-1:0]       req_ready,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic              [31:0]              out_addr,
    output logic              [31:0]              out_data,
    output logic              [SRC_W-1:0]         out_src,
    output logic                                  full,
    output logic                                  done,
    output logic                                  err_illegal
);

    localparam int               CNT_W   = $clog2(MAX_INSTRS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INSTRS);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] issued_cnt;
    logic [SRC_W-1:0] rr_ptr, rr_next;
    logic [SRC_W-1:0] grant;
    logic             grant_vld;
    logic             can_accept;
    logic             accept;
    logic [31:0]      enc_word;
    logic             enc_illegal;
`ifdef VX_TB_INST_ARB_LOCK_EN
    logic             lock_q;
`endif

    function automatic logic [SRC_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return SRC_W'(s);
    endfunction

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        grant     = rr_ptr;
        grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_vld && req_valid[wrap_idx(int'(rr_ptr), i)]) begin
                grant     = wrap_idx(int'(rr_ptr), i);
                grant_vld = 1'b1;
            end
        end
`ifdef VX_TB_INST_ARB_LOCK_EN
        // A held lock pins the grant to rr_ptr; nobody else is served even
        // while the holder has nothing to offer.
        if (lock_q) begin
            grant     = rr_ptr;
            grant_vld = req_valid[rr_ptr];
        end
`endif
    end

    assign full       = (issued_cnt == MAX_CNT);
    assign can_accept = !clear && (issued_cnt < MAX_CNT)
                        && (state_q == ARB_IDLE || out_ready);
    assign accept     = grant_vld && can_accept;
    assign out_valid  = (state_q == ARB_EMIT);
    assign done       = full && !out_valid;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
    end

    always_comb begin
        rr_next = rr_ptr;
        if (accept) begin
            rr_next = (int'(grant) == NUM_REQ - 1) ? '0 : grant + SRC_W'(1);
`ifdef VX_TB_INST_ARB_LOCK_EN
            if (req_lock[grant]) rr_next = grant;
`endif
        end
    end

    risc_v_inst_encoder u_encoder (
        .instr   (req_instr[grant]),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Output-register FSM. An accept refills the register in the same cycle
    // the loader takes the old word, giving one word per cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (accept) state_d = ARB_EMIT;
            ARB_EMIT: if (!accept && out_ready) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
        if (clear) state_d = ARB_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ARB_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_addr    <= BASE_ADDR;
            out_data    <= '0;
            out_src     <= '0;
            issued_cnt  <= '0;
            rr_ptr      <= '0;
            err_illegal <= 1'b0;
        end else if (clear) begin
            issued_cnt  <= '0;
            rr_ptr      <= '0;
            err_illegal <= 1'b0;
        end else begin
            rr_ptr <= rr_next;
            if (accept) begin
                out_data    <= enc_word;
                out_addr    <= BASE_ADDR + (32'(issued_cnt) << 2);
                out_src     <= grant;
                issued_cnt  <= issued_cnt + CNT_W'(1);
                err_illegal <= err_illegal | enc_illegal;
            end
        end
    end

`ifdef VX_TB_INST_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    lock_q <= 1'b0;
        else if (clear)  lock_q <= 1'b0;
        else if (accept) lock_q <= req_lock[grant];
    end
`endif

endmodule

// File: tb/tb_risc_v_inst_arbiter.sv
// ----------------------------------------------------------------------------
// tb_risc_v_inst_arbiter
// Self-checking bench for risc_v_inst_arbiter (NUM_REQ=4, MAX_INSTRS=8).
// A negedge monitor keeps a behavioural model of grant order, fill count and
// output state; accepted instructions push expected {addr,word,src} entries
// that are popped when the loader takes a word. Lock scenarios run when
// VX_TB_INST_ARB_LOCK_EN is defined.
// ----------------------------------------------------------------------------
module tb_risc_v_inst_arbiter;
    import VX_tb_common_pkg::*;

    localparam int          NUM_REQ = 4;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          MAX_I   = 8;

    logic                              clk       = 1'b0;
    logic                              reset_n   = 1'b0;
    logic                              clear     = 1'b0;
    logic              [NUM_REQ-1:0]   req_valid = '0;
    risc_v_seq_instr_t [NUM_REQ-1:0]   req_instr = '0;
    logic              [NUM_REQ-1:0]   req_lock  = '0;
    logic              [NUM_REQ-1:0]   req_ready;
    logic                              out_valid;
    logic                              out_ready = 1'b1;
    logic              [31:0]          out_addr;
    logic              [31:0]          out_data;
    logic              [1:0]           out_src;
    logic                              full;
    logic                              done;
    logic                              err_illegal;

    risc_v_inst_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .BASE_ADDR  (BASE),
        .MAX_INSTRS (MAX_I)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_instr   (req_instr),
`ifdef VX_TB_INST_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_src     (out_src),
        .full        (full),
        .done        (done),
        .err_illegal (err_illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder built from bit positions with shifts and masks.
    function automatic void m_encode(input risc_v_seq_instr_t x,
                                     output logic [31:0] w, output bit ill);
        logic [31:0] op, rd, f3, rs1, rs2, f7, i0, i1;
        op = 32'(x.opcode); rd = 32'(x.rd); f3 = 32'(x.funct3);
        rs1 = 32'(x.rs1); rs2 = 32'(x.rs2); f7 = 32'(x.funct7);
        i0 = x.imm0; i1 = x.imm1;
        ill = 1'b0;
        case (int'(x.instr_type))
            0: w = op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
            1: w = op | rd << 7 | f3 << 12 | rs1 << 15 | (i0 & 32'hfff) << 20;
            2: w = op | (i0 & 32'h1f) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20
                   | ((i1 >> 5) & 32'h7f) << 25;
            3: w = op | ((i0 >> 11) & 32'h1) << 7 | ((i0 >> 1) & 32'hf) << 8
                   | f3 << 12 | rs1 << 15 | rs2 << 20
                   | ((i1 >> 5) & 32'h3f) << 25 | ((i1 >> 12) & 32'h1) << 31;
            4: w = op | rd << 7 | (i0 & 32'hffff_f000);
            5: w = op | rd << 7 | ((i0 >> 12) & 32'hff) << 12
                   | ((i0 >> 11) & 32'h1) << 20 | ((i1 >> 1) & 32'h3ff) << 21
                   | ((i1 >> 20) & 32'h1) << 31;
            default: begin w = 32'h0000_0013; ill = 1'b1; end
        endcase
    endfunction

    function automatic risc_v_seq_instr_t rand_instr(input bit allow_illegal);
        risc_v_seq_instr_t x;
        x.instr_type = instr_type_e'(3'($urandom_range(0, allow_illegal ? 7 : 5)));
        x.opcode = 7'($urandom); x.rd = 5'($urandom); x.rs1 = 5'($urandom);
        x.rs2 = 5'($urandom); x.funct3 = 3'($urandom); x.funct7 = 7'($urandom);
        x.imm0 = $urandom; x.imm1 = $urandom;
        return x;
    endfunction

    // ---------------- model + scoreboard ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          src;
    } exp_t;

    exp_t        sb_q[$];
    int          grant_log[$];
    int          n_pops = 0;
    bit          mon_en = 1'b0;
    int          m_rr, m_cnt;
    bit          m_outv, m_err, m_lock;
    bit          prev_stall;
    logic [31:0] prev_addr, prev_data, prev_src;

    task automatic model_reset();
        m_rr = 0; m_cnt = 0; m_outv = 0; m_err = 0; m_lock = 0;
        prev_stall = 0;
        sb_q.delete();
    endtask

    always @(negedge clk) begin
        int           eg, idx;
        bit           ev, can, ill;
        logic [3:0]   er;
        logic [31:0]  w;
        exp_t         e;
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(m_outv));
            check("full", 32'(full), 32'(m_cnt == MAX_I));
            check("done", 32'(done), 32'(m_cnt == MAX_I && !m_outv));
            check("err_illegal", 32'(err_illegal), 32'(m_err));
            if (prev_stall) begin
                check("stall_addr", out_addr, prev_addr);
                check("stall_data", out_data, prev_data);
                check("stall_src", 32'(out_src), prev_src);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    n_pops++;
                    check("sb_addr", out_addr, e.addr);
                    check("sb_data", out_data, e.data);
                    check("sb_src", 32'(out_src), 32'(e.src));
                end
            end
            eg = m_rr; ev = 1'b0;
            if (m_lock) begin
                ev = req_valid[m_rr];
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_rr + k) % NUM_REQ;
                    if (!ev && req_valid[idx]) begin eg = idx; ev = 1'b1; end
                end
            end
            can = !clear && m_cnt < MAX_I && (!m_outv || out_ready);
            er  = (can && ev) ? (4'b0001 << eg) : 4'b0000;
            check("req_ready", 32'(req_ready), 32'(er));

            prev_stall = out_valid && !out_ready && !clear;
            prev_addr  = out_addr; prev_data = out_data; prev_src = 32'(out_src);

            if (clear) begin
                model_reset();
            end else if (can && ev) begin
                grant_log.push_back(eg);
                m_encode(req_instr[eg], w, ill);
                e.addr = BASE + 32'(4 * m_cnt); e.data = w; e.src = eg;
                sb_q.push_back(e);
                m_cnt++;
                m_err  = m_err | ill;
                m_outv = 1'b1;
                if (req_lock[eg]) begin m_lock = 1'b1; m_rr = eg; end
                else begin m_lock = 1'b0; m_rr = (eg + 1) % NUM_REQ; end
            end else if (m_outv && out_ready) begin
                m_outv = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(); clear = 1'b0;
    endtask

    initial begin
        risc_v_seq_instr_t add_x3;
        int pops0;
        int exp_order[5] = '{0, 1, 2, 3, 0};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", out_addr, BASE);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_src", 32'(out_src), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        cyc();

        // add x3,x1,x2 from requester 0
        add_x3 = '0;
        add_x3.instr_type = INSTR_R; add_x3.opcode = 7'h33;
        add_x3.rd = 5'd3; add_x3.rs1 = 5'd1; add_x3.rs2 = 5'd2;
        req_instr[0] = add_x3;
        req_valid = 4'b0001;
        cyc();
        req_valid = 4'b0000;
        check("add_data", out_data, 32'h0020_81B3);
        check("add_addr", out_addr, 32'h8000_0000);
        check("add_src", 32'(out_src), 32'd0);
        cyc();

        // Round-robin with every requester valid
        do_clear();
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) req_instr[i] = rand_instr(1'b0);
        req_valid = 4'b1111;
        repeat (5) cyc();
        req_valid = 4'b0000;
        cyc();
        check("rr_count", 32'(grant_log.size()), 32'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            check("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));

        // Loader stall for 5 cycles
        do_clear();
        pops0 = n_pops;
        req_valid = 4'b0100;
        cyc();
        req_valid = 4'b0001;
        out_ready = 1'b0;
        repeat (5) cyc();
        out_ready = 1'b1;
        cyc();
        req_valid = 4'b0000;
        repeat (2) cyc();
        check("stall_pops", 32'(n_pops - pops0), 32'd2);
        check("stall_sb_empty", 32'(sb_q.size()), 32'd0);

        // Fill to MAX_INSTRS, drain, then restart
        do_clear();
        grant_log.delete();
        req_valid = 4'b1111;
        for (int i = 0; i < 40 && !full; i++) cyc();
        check("fill_full", 32'(full), 32'd1);
        repeat (3) cyc();
        req_valid = 4'b0000;
        cyc();
        check("fill_done", 32'(done), 32'd1);
        check("fill_accepts", 32'(grant_log.size()), 32'(MAX_I));
        do_clear();
        req_valid = 4'b0010;
        cyc();
        req_valid = 4'b0000;
        check("restart_addr", out_addr, BASE);
        check("restart_src", 32'(out_src), 32'd1);
        cyc();

        // Unsupported instr_type
        req_instr[3] = rand_instr(1'b0);
        req_instr[3].instr_type = instr_type_e'(3'd7);
        req_valid = 4'b1000;
        cyc();
        req_valid = 4'b0000;
        check("illegal_nop", out_data, 32'h0000_0013);
        repeat (2) cyc();
        check("illegal_sticky", 32'(err_illegal), 32'd1);
        do_clear();
        check("illegal_cleared", 32'(err_illegal), 32'd0);

`ifdef VX_TB_INST_ARB_LOCK_EN
        // Requester 1 holds the lock across a gap in its valid
        do_clear();
        grant_log.delete();
        req_instr[1] = rand_instr(1'b0);
        req_instr[2] = rand_instr(1'b0);
        req_valid = 4'b0110; req_lock = 4'b0010; cyc();
        req_valid = 4'b0100;                     cyc();
        req_valid = 4'b0110;                     cyc();
        req_lock  = 4'b0000;                     cyc();
        cyc();
        req_valid = 4'b0000;
        cyc();
        check("lock_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("lock_order", 32'(grant_log[i]), (i < 3) ? 32'd1 : 32'd2);
`endif

        // Random traffic
        do_clear();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) req_instr[i] = rand_instr(($urandom_range(0, 15) == 0));
            req_valid = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 15) == 0);
`ifdef VX_TB_INST_ARB_LOCK_EN
            req_lock  = 4'($urandom) & 4'($urandom);
`endif
            cyc();
        end
        clear = 1'b0; req_valid = 4'b0000; req_lock = 4'b0000; out_ready = 1'b1;
        repeat (3) cyc();
        check("rand_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset asserted with a word pending drops it at once
        mon_en = 1'b0;
        req_valid = 4'b0001;
        cyc();
        req_valid = 4'b0000;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_addr", out_addr, BASE);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
